// File: rtl/inst_dec_q.sv
// Decoding instruction queue: RV32IM words are decoded as they are enqueued, and the
// decoded bundle plus PC is buffered in a DEPTH-entry FIFO for the execute stage.
module inst_dec_q #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_inst_data,
  input  logic [XLEN-1:0]            i_pc,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [XLEN-1:0]            o_pc,
  output logic [4:0]                 o_rd,
  output logic [4:0]                 o_rs1,
  output logic [4:0]                 o_rs2,
  output logic [XLEN-1:0]            o_imm,
  output logic [2:0]                 o_funct3,
  output logic                       o_alusrc,
  output logic                       o_use_pc,
  output logic                       o_mem_to_reg,
  output logic                       o_reg_write,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic                       o_branch,
  output logic                       o_jump,
  output logic                       o_illegal,
  output logic [2:0]                 o_op_mode,
  output logic [2:0]                 o_func_op,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] M_LOG = 3'd1, M_SFT = 3'd2, M_CMP = 3'd3, M_ADD = 3'd4,
                         M_MUL = 3'd5, M_DIV = 3'd6, M_REM = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            alusrc;
    logic            use_pc;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [2:0]      op_mode;
    logic [2:0]      func_op;
  } bundle_t;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            legal;
  bundle_t         dec;

  assign opc   = i_inst_data[6:0];
  assign f3    = i_inst_data[14:12];
  assign f7    = i_inst_data[31:25];
  assign rd_f  = i_inst_data[11:7];
  assign rs1_f = i_inst_data[19:15];
  assign rs2_f = i_inst_data[24:20];
  assign imm_i = XLEN'($signed(i_inst_data[31:20]));
  assign imm_s = XLEN'($signed({i_inst_data[31:25], i_inst_data[11:7]}));
  assign imm_b = XLEN'($signed({i_inst_data[31], i_inst_data[7], i_inst_data[30:25],
                                i_inst_data[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i_inst_data[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i_inst_data[31], i_inst_data[19:12], i_inst_data[20],
                                i_inst_data[30:21], 1'b0}));

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opc)
      7'b0110111: begin // LUI
        dec.rd = rd_f; dec.imm = imm_u; dec.alusrc = 1'b1; dec.reg_write = 1'b1;
        dec.op_mode = M_ADD;
      end
      7'b0010111: begin // AUIPC
        dec.rd = rd_f; dec.imm = imm_u; dec.alusrc = 1'b1; dec.use_pc = 1'b1;
        dec.reg_write = 1'b1; dec.op_mode = M_ADD;
      end
      7'b1101111: begin // JAL
        dec.rd = rd_f; dec.imm = imm_j; dec.use_pc = 1'b1; dec.jump = 1'b1;
        dec.reg_write = 1'b1; dec.op_mode = M_ADD;
      end
      7'b1100111: begin // JALR
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i; dec.alusrc = 1'b1;
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.op_mode = M_ADD;
        legal = (f3 == 3'b000);
      end
      7'b1100011: begin // BRANCH
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_b; dec.branch = 1'b1;
        dec.op_mode = M_CMP;
        case (f3)
          3'b000:  dec.func_op = 3'd5;
          3'b001:  dec.func_op = 3'd4;
          3'b100:  dec.func_op = 3'd0;
          3'b101:  dec.func_op = 3'd3;
          3'b110:  dec.func_op = 3'd1;
          3'b111:  dec.func_op = 3'd2;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin // LOAD
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i; dec.alusrc = 1'b1;
        dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
        dec.op_mode = M_ADD;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      7'b0100011: begin // STORE
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_s; dec.alusrc = 1'b1;
        dec.mem_write = 1'b1; dec.op_mode = M_ADD;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end
      7'b0010011: begin // OP-IMM; shift immediates keep the funct7 bits as decoded
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i; dec.alusrc = 1'b1;
        dec.reg_write = 1'b1;
        case (f3)
          3'b000: dec.op_mode = M_ADD;
          3'b010: dec.op_mode = M_CMP;
          3'b011: begin dec.op_mode = M_CMP; dec.func_op = 3'd1; end
          3'b100: begin dec.op_mode = M_LOG; dec.func_op = 3'd2; end
          3'b110: begin dec.op_mode = M_LOG; dec.func_op = 3'd1; end
          3'b111: dec.op_mode = M_LOG;
          3'b001: begin dec.op_mode = M_SFT; legal = (f7 == 7'b0000000); end
          default: begin
            dec.op_mode = M_SFT;
            if (f7 == 7'b0000000)      dec.func_op = 3'd2;
            else if (f7 == 7'b0100000) dec.func_op = 3'd3;
            else                       legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin // OP
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.reg_write = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec.op_mode = M_ADD;
          10'b0100000_000: begin dec.op_mode = M_ADD; dec.func_op = 3'd1; end
          10'b0000000_001: dec.op_mode = M_SFT;
          10'b0000000_010: dec.op_mode = M_CMP;
          10'b0000000_011: begin dec.op_mode = M_CMP; dec.func_op = 3'd1; end
          10'b0000000_100: begin dec.op_mode = M_LOG; dec.func_op = 3'd2; end
          10'b0000000_101: begin dec.op_mode = M_SFT; dec.func_op = 3'd2; end
          10'b0100000_101: begin dec.op_mode = M_SFT; dec.func_op = 3'd3; end
          10'b0000000_110: begin dec.op_mode = M_LOG; dec.func_op = 3'd1; end
          10'b0000000_111: dec.op_mode = M_LOG;
          10'b0000001_000: dec.op_mode = M_MUL;
          10'b0000001_100: dec.op_mode = M_DIV;
          10'b0000001_110: dec.op_mode = M_REM;
          default:         legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.funct3 = f3;
    dec.pc     = i_pc;
  end

  bundle_t         mem [DEPTH];
  bundle_t         out_q, out_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy_q, rdy_d;
  logic            push, pop;

  assign push = i_valid && rdy_q;
  assign pop  = (count_q != '0) && i_ready;

  always_comb begin
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    out_d   = out_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else if (count_d != '0) begin
      // A push into a queue that is empty after this cycle's pop becomes the new head.
      out_d = (push && (count_q == CW'(pop))) ? dec : mem[rptr_d];
    end
    rdy_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem[wptr_q] <= dec;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdy_q   <= rdy_d;
      out_q   <= out_d;
    end
  end

  assign o_ready      = rdy_q;
  assign o_valid      = (count_q != '0);
  assign o_count      = count_q;
  assign o_pc         = out_q.pc;
  assign o_rd         = out_q.rd;
  assign o_rs1        = out_q.rs1;
  assign o_rs2        = out_q.rs2;
  assign o_imm        = out_q.imm;
  assign o_funct3     = out_q.funct3;
  assign o_alusrc     = out_q.alusrc;
  assign o_use_pc     = out_q.use_pc;
  assign o_mem_to_reg = out_q.mem_to_reg;
  assign o_reg_write  = out_q.reg_write;
  assign o_mem_read   = out_q.mem_read;
  assign o_mem_write  = out_q.mem_write;
  assign o_branch     = out_q.branch;
  assign o_jump       = out_q.jump;
  assign o_illegal    = out_q.illegal;
  assign o_op_mode    = out_q.op_mode;
  assign o_func_op    = out_q.func_op;
endmodule

// File: tb/tb_inst_dec_q.sv
// Scoreboard bench for inst_dec_q: hand-derived decoded bundles are queued on each
// accepted push and compared against the head outputs on each pop.
module tb_inst_dec_q;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [31:0] i_inst_data = '0;
  logic [XLEN-1:0] i_pc = '0;
  logic o_ready, o_valid;
  logic [XLEN-1:0] o_pc, o_imm;
  logic [4:0] o_rd, o_rs1, o_rs2;
  logic [2:0] o_funct3, o_op_mode, o_func_op;
  logic o_alusrc, o_use_pc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write;
  logic o_branch, o_jump, o_illegal;
  logic [$clog2(DEPTH+1)-1:0] o_count;

  inst_dec_q #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst_data(i_inst_data), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_imm(o_imm), .o_funct3(o_funct3), .o_alusrc(o_alusrc), .o_use_pc(o_use_pc),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_branch(o_branch), .o_jump(o_jump),
    .o_illegal(o_illegal), .o_op_mode(o_op_mode), .o_func_op(o_func_op),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // flag order: alusrc, use_pc, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, illegal
  localparam logic [8:0] F_ALU = 9'h100, F_PC = 9'h080, F_M2R = 9'h040, F_RW = 9'h020,
                         F_MR = 9'h010, F_MW = 9'h008, F_BR = 9'h004, F_JMP = 9'h002,
                         F_ILL = 9'h001;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [8:0]  fl;
    logic [2:0]  opm, fop;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int checks = 0, passes = 0, fails = 0;

  function automatic exp_t mk(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [31:0] imm, logic [2:0] f3,
                              logic [8:0] fl, logic [2:0] opm, logic [2:0] fop);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.f3 = f3;
    e.fl = fl; e.opm = opm; e.fop = fop;
    return e;
  endfunction

  function automatic logic [31:0] addi_w(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic exp_t addi_e(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                                  logic [11:0] imm);
    return mk(pc, rd, rs1, 5'd0, {{20{imm[11]}}, imm}, 3'd0, F_ALU | F_RW, 3'd4, 3'd0);
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.pc = o_pc; o.rd = o_rd; o.rs1 = o_rs1; o.rs2 = o_rs2; o.imm = o_imm; o.f3 = o_funct3;
    o.fl = {o_alusrc, o_use_pc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write,
            o_branch, o_jump, o_illegal};
    o.opm = o_op_mode; o.fop = o_func_op;
    return o;
  endfunction

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic offer(logic [31:0] inst, logic [31:0] pc, exp_t e);
    i_valid = 1'b1; i_inst_data = inst; i_pc = pc; cur = e;
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; advances one clock.
  task automatic cycle();
    exp_t e;
    if (!i_flush && o_valid && i_ready) begin
      if (q.size() == 0) chk("pop_unexpected", 128'(o_valid), 128'd0);
      else begin
        e = q.pop_front();
        chk("pop_bundle", 128'(obs()), 128'(e));
      end
    end
    if (!i_flush && i_valid && o_ready) q.push_back(cur);
    if (i_flush) q.delete();
    @(posedge i_clk);
    @(negedge i_clk);
    chk("count", 128'(o_count), 128'(q.size()));
    chk("valid", 128'(o_valid), 128'(q.size() != 0));
    chk("ready", 128'(o_ready), 128'(q.size() < DEPTH));
  endtask

  logic [31:0] dir_w [10];
  exp_t        dir_e [10];

  initial begin
    // reset state
    #12;
    chk("rst_valid", 128'(o_valid), 128'd0);
    chk("rst_ready", 128'(o_ready), 128'd0);
    chk("rst_count", 128'(o_count), 128'd0);
    chk("rst_bundle", 128'(obs()), 128'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("ready_after_rst", 128'(o_ready), 128'd1);

    // ADDI x5,x1,-1 into an empty queue
    i_ready = 1'b0;
    offer(32'hFFF08293, 32'h100,
          mk(32'h100, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF, 3'd0, F_ALU | F_RW, 3'd4, 3'd0));
    cycle();
    idle();
    chk("addi_head", 128'(obs()), 128'(cur));
    chk("addi_mem_read", 128'(o_mem_read), 128'd0);
    i_ready = 1'b1;
    cycle();

    // fill to DEPTH with the consumer stalled, then offer a fifth word
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      offer(addi_w(5'(k + 1), 5'd2, 12'(k * 3)), 32'h200 + 32'(4 * k),
            addi_e(32'h200 + 32'(4 * k), 5'(k + 1), 5'd2, 12'(k * 3)));
      cycle();
    end
    chk("full_ready", 128'(o_ready), 128'd0);
    chk("full_count", 128'(o_count), 128'(DEPTH));
    offer(addi_w(5'd9, 5'd9, 12'h7FF), 32'h2F0, addi_e(32'h2F0, 5'd9, 5'd9, 12'h7FF));
    cycle();
    chk("fifth_refused", 128'(o_count), 128'(DEPTH));
    idle();
    i_ready = 1'b1;
    cycle();
    chk("ready_after_pop", 128'(o_ready), 128'd1);
    for (int k = 0; k < DEPTH - 1; k++) cycle();

    // steady push+pop for 20 cycles at occupancy 2, pointers wrap several times
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(addi_w(5'(k + 1), 5'd3, 12'(k)), 32'h1000 + 32'(4 * k),
            addi_e(32'h1000 + 32'(4 * k), 5'(k + 1), 5'd3, 12'(k)));
      cycle();
    end
    i_ready = 1'b1;
    for (int k = 2; k < 22; k++) begin
      offer(addi_w(5'(k % 31 + 1), 5'd3, 12'(k * 7 + 2048)), 32'h1000 + 32'(4 * k),
            addi_e(32'h1000 + 32'(4 * k), 5'(k % 31 + 1), 5'd3, 12'(k * 7 + 2048)));
      cycle();
      chk("steady_count", 128'(o_count), 128'd2);
    end
    idle();
    cycle();
    cycle();

    // directed decode cases, each pushed and popped back-to-back
    dir_w[0] = 32'h123451B7; // LUI x3,0x12345
    dir_e[0] = mk(32'h300, 5'd3, 5'd0, 5'd0, 32'h12345000, 3'd5, F_ALU | F_RW, 3'd4, 3'd0);
    dir_w[1] = 32'hFE20AE23; // SW x2,-4(x1)
    dir_e[1] = mk(32'h304, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 3'd2, F_ALU | F_MW, 3'd4, 3'd0);
    dir_w[2] = 32'h010000EF; // JAL x1,+16
    dir_e[2] = mk(32'h308, 5'd1, 5'd0, 5'd0, 32'd16, 3'd0, F_PC | F_JMP | F_RW, 3'd4, 3'd0);
    dir_w[3] = 32'h022081B3; // MUL x3,x1,x2
    dir_e[3] = mk(32'h30C, 5'd3, 5'd1, 5'd2, 32'd0, 3'd0, F_RW, 3'd5, 3'd0);
    dir_w[4] = 32'h40208233; // SUB x4,x1,x2
    dir_e[4] = mk(32'h310, 5'd4, 5'd1, 5'd2, 32'd0, 3'd0, F_RW, 3'd4, 3'd1);
    dir_w[5] = 32'h4033D313; // SRAI x6,x7,3
    dir_e[5] = mk(32'h314, 5'd6, 5'd7, 5'd0, 32'h403, 3'd5, F_ALU | F_RW, 3'd2, 3'd3);
    dir_w[6] = 32'hFFFFFFFF; // illegal opcode
    dir_e[6] = mk(32'h318, 5'd0, 5'd0, 5'd0, 32'd0, 3'd7, F_ILL, 3'd0, 3'd0);
    dir_w[7] = 32'h0020E463; // BLTU x1,x2,+8
    dir_e[7] = mk(32'h31C, 5'd0, 5'd1, 5'd2, 32'd8, 3'd6, F_BR, 3'd3, 3'd1);
    dir_w[8] = 32'h0080A283; // LW x5,8(x1)
    dir_e[8] = mk(32'h320, 5'd5, 5'd1, 5'd0, 32'd8, 3'd2, F_ALU | F_M2R | F_RW | F_MR,
                  3'd4, 3'd0);
    dir_w[9] = 32'h022091B3; // MULH: unlisted funct3 under funct7=0000001
    dir_e[9] = mk(32'h324, 5'd0, 5'd0, 5'd0, 32'd0, 3'd1, F_ILL, 3'd0, 3'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      offer(dir_w[k], 32'h300 + 32'(4 * k), dir_e[k]);
      cycle();
    end
    idle();
    cycle();

    // flush at count 3 with a coincident push and pop
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(addi_w(5'(k + 10), 5'd4, 12'(k + 100)), 32'h400 + 32'(4 * k),
            addi_e(32'h400 + 32'(4 * k), 5'(k + 10), 5'd4, 12'(k + 100)));
      cycle();
    end
    chk("pre_flush_count", 128'(o_count), 128'd3);
    offer(addi_w(5'd20, 5'd4, 12'd200), 32'h4F0, addi_e(32'h4F0, 5'd20, 5'd4, 12'd200));
    i_ready = 1'b1;
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    chk("flush_count", 128'(o_count), 128'd0);
    chk("flush_valid", 128'(o_valid), 128'd0);
    offer(addi_w(5'd21, 5'd5, 12'd300), 32'h500, addi_e(32'h500, 5'd21, 5'd5, 12'd300));
    cycle();
    idle();
    cycle();

    // asynchronous reset mid-burst at count 2
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(addi_w(5'(k + 1), 5'd6, 12'(k)), 32'h600 + 32'(4 * k),
            addi_e(32'h600 + 32'(4 * k), 5'(k + 1), 5'd6, 12'(k)));
      cycle();
    end
    chk("pre_rst_count", 128'(o_count), 128'd2);
    offer(addi_w(5'd7, 5'd6, 12'd7), 32'h608, addi_e(32'h608, 5'd7, 5'd6, 12'd7));
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(o_valid), 128'd0);
    chk("async_rst_ready", 128'(o_ready), 128'd0);
    q.delete();
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("post_rst_count", 128'(o_count), 128'd0);
    chk("post_rst_ready", 128'(o_ready), 128'd1);
    i_ready = 1'b1;
    offer(addi_w(5'd8, 5'd1, 12'd8), 32'h700, addi_e(32'h700, 5'd8, 5'd1, 12'd8));
    cycle();
    idle();
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
